// File: rtl/hv_pwm_intb_encode_pkg.sv
// hv_pwm_intb_encode_pkg: shared HV/LV PWM-INTB line code states and constants
package hv_pwm_intb_encode_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP, GUARD} pwm_state_e;
  localparam int PWM_PULSE_W = 5;
  localparam int PWM_GAP_W = 2;
  localparam int PWM_GUARD_W = 16;
  localparam int PWM_REFRESH_CYC = 1024;
  localparam int PWM_N_ASSERT = 1;
  localparam int PWM_N_DEASSERT = 4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/hv_pwm_intb_encode.sv
// hv_pwm_intb_encode: serialises the HV interrupt level into 1-pulse / 4-pulse PWM frames
module hv_pwm_intb_encode
  import hv_pwm_intb_encode_pkg::*;
#(
  parameter int PULSE_W = PWM_PULSE_W,
  parameter int GAP_W = PWM_GAP_W,
  parameter int GUARD_W = PWM_GUARD_W,
  parameter int REFRESH_CYC = PWM_REFRESH_CYC
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hv_intb_n,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_frame_done
);
  localparam int CW = $clog2(max3(PULSE_W, GAP_W, GUARD_W) + 1);
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC + 1) : 1;
  localparam logic [CW-1:0] P_END = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_END = CW'(GAP_W - 1);
  localparam logic [CW-1:0] D_END = CW'(GUARD_W - 1);
  localparam logic [CW-1:0] D_PRE = CW'(GUARD_W - 2);
  localparam logic [RW-1:0] R_END = RW'((REFRESH_CYC == 0) ? 0 : REFRESH_CYC - 1);
  localparam logic [2:0] N_LO = 3'(PWM_N_ASSERT);
  localparam logic [2:0] N_HI = 3'(PWM_N_DEASSERT);
  pwm_state_e state;
  logic sent_lvl, frm_lvl, start;
  logic [2:0] pls_left;
  logic [CW-1:0] cyc_cnt;
  logic [RW-1:0] ref_cnt;
  assign start = (i_hv_intb_n != sent_lvl) || (REFRESH_CYC != 0 && ref_cnt == R_END);
  // outputs are registered alongside the state so the line is high exactly in PULSE cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      sent_lvl <= 1'b1;
      frm_lvl <= 1'b1;
      pls_left <= '0;
      cyc_cnt <= '0;
      ref_cnt <= '0;
      o_hv_pwm_intb_n <= 1'b0;
      o_busy <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PULSE;
            frm_lvl <= i_hv_intb_n;
            sent_lvl <= i_hv_intb_n;
            pls_left <= i_hv_intb_n ? N_HI : N_LO;
            cyc_cnt <= '0;
            ref_cnt <= '0;
            o_hv_pwm_intb_n <= 1'b1;
            o_busy <= 1'b1;
          end else begin
            ref_cnt <= (ref_cnt == R_END) ? ref_cnt : ref_cnt + 1'b1;
          end
        end
        PULSE: begin
          ref_cnt <= '0;
          if (cyc_cnt == P_END) begin
            cyc_cnt <= '0;
            o_hv_pwm_intb_n <= 1'b0;
            state <= (pls_left > 3'd1) ? GAP : GUARD;
            pls_left <= (pls_left > 3'd1) ? pls_left - 1'b1 : pls_left;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        GAP: begin
          ref_cnt <= '0;
          if (cyc_cnt == G_END) begin
            cyc_cnt <= '0;
            state <= PULSE;
            o_hv_pwm_intb_n <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          ref_cnt <= '0;
          if (cyc_cnt == D_END) begin
            cyc_cnt <= '0;
            state <= IDLE;
            sent_lvl <= frm_lvl;
            o_busy <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            o_frame_done <= (cyc_cnt == D_PRE);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// tb_hv_pwm_intb_encode: frame-level reference model plus line decoder against two encoder instances
module tb_hv_pwm_intb_encode;
  localparam int P = 5;
  localparam int G = 2;
  localparam int GD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in = 2'b11;
  logic [1:0] pwm, busy, done;
  int n_tests = 0;
  int n_fail = 0;
  logic [2:0] q [2][$];
  logic sent_m [2];
  int idle_m [2];
  logic dec = 1'b1;
  logic prev0 = 1'b0;
  logic pb1 = 1'b0;
  logic flvl = 1'b1;
  logic seen0 = 1'b0;
  int pcnt = 0;
  int low = 0;
  int blen = 0;
  int gap1 = 0;
  int last_gap1 = 0;

  always #5 clk = ~clk;

  hv_pwm_intb_encode #(.REFRESH_CYC(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_hv_intb_n(in[0]),
    .o_hv_pwm_intb_n(pwm[0]), .o_busy(busy[0]), .o_frame_done(done[0])
  );
  hv_pwm_intb_encode #(.REFRESH_CYC(64)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_hv_intb_n(in[1]),
    .o_hv_pwm_intb_n(pwm[1]), .o_busy(busy[1]), .o_frame_done(done[1])
  );

  function automatic int rc(int k);
    return (k == 0) ? 0 : 64;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a frame as seen on {line,busy,done}: pulses, gaps, guard, then the return-to-idle cycle
  task automatic build(input int k, input logic lvl);
    int n;
    n = lvl ? 4 : 1;
    for (int p = 0; p < n; p++) begin
      repeat (P) q[k].push_back(3'b110);
      if (p < n - 1) repeat (G) q[k].push_back(3'b010);
    end
    repeat (GD - 1) q[k].push_back(3'b010);
    q[k].push_back(3'b011);
    q[k].push_back(3'b000);
  endtask

  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sent_m[k] = 1'b1;
        q[k].delete();
        idle_m[k] = 0;
        e = 3'b000;
      end else if (q[k].size() != 0) begin
        e = q[k].pop_front();
        idle_m[k] = 0;
      end else if (in[k] !== sent_m[k] || (rc(k) != 0 && idle_m[k] == rc(k) - 1)) begin
        build(k, in[k]);
        sent_m[k] = in[k];
        e = q[k].pop_front();
        idle_m[k] = 0;
      end else begin
        e = 3'b000;
        if (rc(k) != 0 && idle_m[k] < rc(k) - 1) idle_m[k]++;
      end
      check(k == 0 ? "out0" : "out1", {29'd0, pwm[k], busy[k], done[k]}, {29'd0, e});
    end
    if (rst) begin
      dec = 1'b1;
      pcnt = 0;
      low = 0;
      blen = 0;
      gap1 = 0;
    end else begin
      if (pwm[0] && !prev0) pcnt++;
      low = pwm[0] ? 0 : low + 1;
      if (low == 10 && pcnt != 0) begin
        dec = (pcnt == 4) ? 1'b1 : (pcnt == 1) ? 1'b0 : dec;
        pcnt = 0;
      end
      if (done[0]) check("decode", {31'd0, dec}, {31'd0, sent_m[0]});
      if (busy[0]) begin
        if (blen == 0) flvl = sent_m[0];
        blen++;
      end else if (blen != 0) begin
        check("frame_len", blen, flvl ? 4 * P + 3 * G + GD : P + GD);
        blen = 0;
      end
      if (busy[1] && !pb1) last_gap1 = gap1;
      gap1 = busy[1] ? 0 : gap1 + 1;
    end
    if (busy[0]) seen0 = 1'b1;
    prev0 = pwm[0];
    pb1 = busy[1];
  endtask

  initial begin
    repeat (3) tick();
    check("rst_sent_lvl", {31'd0, dut0.sent_lvl}, 32'd1);
    rst = 1'b0;
    seen0 = 1'b0;
    repeat (2000) tick();
    check("idle_hold", {31'd0, seen0}, 32'd0);
    in[0] = 1'b0;
    tick();
    check("latency", {31'd0, pwm[0]}, 32'd1);
    repeat (60) tick();
    in[0] = 1'b1;
    repeat (12) tick();
    in[0] = 1'b0;
    repeat (3) tick();
    in[0] = 1'b1;
    repeat (80) tick();
    in[0] = 1'b0;
    repeat (8) tick();
    in[0] = 1'b1;
    repeat (100) tick();
    in[1] = 1'b0;
    repeat (300) tick();
    check("refresh_gap", last_gap1, 32'd64);
    repeat (40) begin
      in = 2'($urandom);
      repeat ($urandom_range(1, 90)) tick();
    end
    in[0] = 1'b0;
    repeat (60) tick();
    in[0] = 1'b1;
    repeat (10) tick();
    check("pulse2_c3", {31'd0, pwm[0]}, 32'd1);
    rst = 1'b1;
    in[0] = 1'b0;
    tick();
    check("rst_line", {31'd0, pwm[0]}, 32'd0);
    check("rst_sent", {31'd0, dut0.sent_lvl}, 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_frame", {31'd0, pwm[0]}, 32'd1);
    repeat (60) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
